// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment scanner.
// Leading-zero blanking is computed here so it stays next to the display constants.
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] BLANK_NIBBLE = 4'hF;
    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    typedef enum logic {
        GUARD,
        DRIVE
    } scan_state_t;

    // Digit k (k>0) is blank when it and every higher digit is zero.
    function automatic logic [3:0] lz_blank_mask(input logic [15:0] value);
        logic [3:0] m;
        m = '0;
        m[3] = (value[15:12] == 4'h0);
        m[2] = m[3] && (value[11:8] == 4'h0);
        m[1] = m[2] && (value[7:4] == 4'h0);
        return m;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter, digit index, frame markers and blink phase for the scanner.
// Next-cycle values are exported so the top can register outputs aligned to them.
module seg_slot_timer import seg_pkg::*; #(
    parameter int SLOT_CYCLES = 100000,
    parameter int GUARD_CYCLES = 2000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] idx_nxt,
    output logic       guard_nxt,
    output logic       wrap,
    output logic       frame_now,
    output logic       frame_nxt,
    output logic       blink_on
);

    localparam int CW = $clog2(SLOT_CYCLES + 1);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    idx;
    logic [FW-1:0] fcnt;

    always_comb begin
        wrap      = (cnt == CW'(SLOT_CYCLES - 1));
        cnt_nxt   = wrap ? '0 : cnt + 1'b1;
        idx_nxt   = wrap ? idx + 1'b1 : idx;
        guard_nxt = (cnt_nxt < CW'(GUARD_CYCLES));
        frame_now = (cnt == '0) && (idx == 2'd0);
        frame_nxt = wrap && (idx == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= 2'd0;
            fcnt     <= '0;
            blink_on <= 1'b1;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
            if (frame_nxt) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt     <= '0;
                    blink_on <= ~blink_on;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit common-anode scanner: shadow/display registers, guard FSM, output mux.
// Outputs are registered from next-cycle timer values so they line up with the slot count.
module seg_scan_mux import seg_pkg::*; #(
    parameter int SLOT_CYCLES = 100000,
    parameter int GUARD_CYCLES = 2000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           value_i,
    input  logic                  load_i,
    input  logic [NUM_DIGITS-1:0] dp_i,
    input  logic                  blank_lz_i,
    input  logic [NUM_DIGITS-1:0] blink_mask_i,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic [3:0]            digit_o,
    output logic                  dp_o,
    output logic                  frame_o
);

    logic [1:0]            idx_nxt;
    logic                  guard_nxt;
    logic                  wrap;
    logic                  frame_now;
    logic                  frame_nxt;
    logic                  blink_on;
    logic [15:0]           shadow_val;
    logic [15:0]           disp_val;
    logic [15:0]           show_val;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [NUM_DIGITS-1:0] show_dp;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  pending;
    logic [3:0]            nib;
    logic [3:0]            eff_nib;
    logic                  eff_dp;
    logic                  blink_off;
    scan_state_t           state;
    scan_state_t           state_nxt;

    seg_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .GUARD_CYCLES(GUARD_CYCLES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx_nxt  (idx_nxt),
        .guard_nxt(guard_nxt),
        .wrap     (wrap),
        .frame_now(frame_now),
        .frame_nxt(frame_nxt),
        .blink_on (blink_on)
    );

    // Look through the transfer so a short guard cannot show a stale frame.
    always_comb begin
        show_val  = (frame_now && pending) ? shadow_val : disp_val;
        show_dp   = (frame_now && pending) ? shadow_dp : disp_dp;
        lz_mask   = lz_blank_mask(show_val);
        nib       = show_val[idx_nxt*4 +: 4];
        blink_off = !blink_on && blink_mask_i[idx_nxt];
        eff_nib   = (blink_off || (blank_lz_i && lz_mask[idx_nxt]))
                    ? BLANK_NIBBLE : nib;
        eff_dp    = blink_off ? 1'b1 : ~show_dp[idx_nxt];
        state_nxt = state;
        unique case (state)
            GUARD: if (!guard_nxt) state_nxt = DRIVE;
            DRIVE: if (wrap && guard_nxt) state_nxt = GUARD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
            state      <= GUARD;
            an_o       <= AN_ALL_OFF;
            digit_o    <= BLANK_NIBBLE;
            dp_o       <= 1'b1;
            frame_o    <= 1'b0;
        end else begin
            if (load_i) begin
                shadow_val <= value_i;
                shadow_dp  <= dp_i;
            end
            if (frame_now && pending) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
            end
            if (load_i) begin
                pending <= 1'b1;
            end else if (frame_now) begin
                pending <= 1'b0;
            end
            state   <= state_nxt;
            frame_o <= frame_nxt;
            unique case (state_nxt)
                GUARD: begin
                    an_o    <= AN_ALL_OFF;
                    digit_o <= BLANK_NIBBLE;
                    dp_o    <= 1'b1;
                end
                DRIVE: begin
                    an_o    <= ~(4'b0001 << idx_nxt);
                    digit_o <= eff_nib;
                    dp_o    <= eff_dp;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux with a frame-level reference model.
// Expected outputs are derived from the cycle count since reset and the load history.
module tb_seg_scan_mux;

    localparam int S  = 8;
    localparam int G  = 2;
    localparam int B  = 2;
    localparam int FR = 4 * S;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dpi;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        dpo;
    logic        frame;

    typedef struct {
        int          c;
        logic [15:0] v;
        logic [3:0]  d;
    } ld_t;

    ld_t        lq[$];
    int         t;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       pb;
    logic [3:0] pm;

    seg_scan_mux #(
        .SLOT_CYCLES (S),
        .GUARD_CYCLES(G),
        .BLINK_FRAMES(B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_i     (value),
        .load_i      (load),
        .dp_i        (dpi),
        .blank_lz_i  (blank_lz),
        .blink_mask_i(blink_mask),
        .an_o        (an),
        .digit_o     (digit),
        .dp_o        (dpo),
        .frame_o     (frame)
    );

    always #5 clk = ~clk;

    // Frame f shows the last value loaded before the frame's first cycle.
    task automatic model(output logic [3:0] e_an, output logic [3:0] e_dg,
                         output logic e_dp, output logic e_fr);
        int s, k, f, h;
        logic [15:0] v;
        logic [3:0] d;
        e_fr = (t % FR == 0) && (t != 0);
        s = t % S;
        k = (t / S) % 4;
        f = t / FR;
        e_an = 4'hF;
        e_dg = 4'hF;
        e_dp = 1'b1;
        if (s >= G) begin
            v = '0;
            d = '0;
            foreach (lq[i]) if (lq[i].c < f * FR) begin
                v = lq[i].v;
                d = lq[i].d;
            end
            h = 0;
            for (int j = 0; j < 4; j++) if (v[4*j +: 4] != 4'h0) h = j;
            e_an[k] = 1'b0;
            e_dg = v[4*k +: 4];
            e_dp = ~d[k];
            if (pb && k > h) e_dg = 4'hF;
            if (((f / B) % 2) == 1 && pm[k]) begin
                e_dg = 4'hF;
                e_dp = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [3:0] e_an, e_dg;
        logic e_dp, e_fr;
        ld_t e;
        model(e_an, e_dg, e_dp, e_fr);
        check("an", an, e_an);
        check("digit", digit, e_dg);
        check("dp", {3'b000, dpo}, {3'b000, e_dp});
        check("frame", {3'b000, frame}, {3'b000, e_fr});
        if (load) begin
            e.c = t;
            e.v = value;
            e.d = dpi;
            lq.push_back(e);
        end
        pb = blank_lz;
        pm = blink_mask;
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_to(input int p);
        while (t % FR != p) cycle();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dpi = d;
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic restart();
        t = 0;
        lq.delete();
        pb = blank_lz;
        pm = blink_mask;
    endtask

    initial begin
        rst_n = 1'b0;
        value = '0;
        load = 1'b0;
        dpi = '0;
        blank_lz = 1'b0;
        blink_mask = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        restart();

        run(40);

        run_to(12);
        do_load(16'h1234, 4'b0100);
        run_to(0);
        run(FR + 1);

        blank_lz = 1'b1;
        do_load(16'h0070, 4'b0000);
        run(2 * FR);
        do_load(16'h0000, 4'b0000);
        run(2 * FR);
        blank_lz = 1'b0;

        run_to(5);
        do_load(16'h1111, 4'b0001);
        run(3);
        do_load(16'h2222, 4'b1000);
        run(2 * FR);

        blink_mask = 4'b0001;
        do_load(16'h5678, 4'b0000);
        run(5 * FR);

        run_to(FR - 1);
        do_load(16'h9ABC, 4'b0011);
        run(2 * FR);

        for (int r = 0; r < 8; r++) begin
            run($urandom_range(1, 40));
            blank_lz = 1'($urandom);
            blink_mask = 4'($urandom);
            do_load(16'($urandom), 4'($urandom));
        end
        run(2 * FR);

        blank_lz = 1'b0;
        blink_mask = 4'b0000;
        do_load(16'h4321, 4'b1111);
        run_to(0);
        run(1);
        run_to(2 * S + 4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_an", an, 4'b1111);
        check("rst_digit", digit, 4'hF);
        check("rst_dp", {3'b000, dpo}, 4'b0001);
        check("rst_frame", {3'b000, frame}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        restart();
        run(3 * FR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
